// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART Tx-side arbitration logic.
package uart_pkg;

  localparam int unsigned C_UART_DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    sIDLE  = 3'd0,
    sSEND  = 3'd1,
    sWAITB = 3'd2,
    sWAITD = 3'd3,
    sDONE  = 3'd4,
    sERR   = 3'd5
  } txArbState_t;

  // Ceiling log2; used for pointer and counter widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART_Tx-side signals of the Tx arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned C_UART_DATA_WIDTH = uart_pkg::C_UART_DATA_WIDTH_DEFAULT,
  parameter int unsigned C_N_REQ           = 3
);

  logic [C_N_REQ-1:0]                   reqValid;
  logic [C_N_REQ*C_UART_DATA_WIDTH-1:0] reqData;
  logic [C_N_REQ-1:0]                   reqGrant;
  logic [C_N_REQ-1:0]                   reqDone;
  logic [C_N_REQ-1:0]                   reqErr;
  logic                                 txBusy;
  logic                                 txSend;
  logic [C_UART_DATA_WIDTH-1:0]         txData;
  logic                                 txErr;

  // Arbiter side.
  modport master (
    input  reqValid, reqData, txBusy, txErr,
    output reqGrant, reqDone, reqErr, txSend, txData
  );

  // Requesters plus UART_Tx side.
  modport slave (
    output reqValid, reqData, txBusy, txErr,
    input  reqGrant, reqDone, reqErr, txSend, txData
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or after rPtr.
module rr_select #(
  parameter int unsigned C_N     = 3,
  parameter int unsigned C_PTR_W = 2
) (
  input  logic [C_N-1:0]     req,
  input  logic [C_PTR_W-1:0] rPtr,
  output logic [C_N-1:0]     grant,
  output logic               found
);

  // Walk positions rPtr, rPtr+1, ... mod C_N; first pending requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < C_N; i++) begin
      for (int unsigned j = 0; j < C_N; j++) begin
        if (!found && req[j] && (((32'(rPtr) + i) % C_N) == j)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART_Tx between several word requesters.
import uart_pkg::*;

module uart_tx_arbiter #(
  parameter int unsigned C_UART_DATA_WIDTH = C_UART_DATA_WIDTH_DEFAULT,
  parameter int unsigned C_N_REQ           = 3,
  parameter int unsigned C_BUSY_TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              enable,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned C_PTR_W = clog2(C_N_REQ);
  localparam int unsigned C_CNT_W = clog2(C_BUSY_TIMEOUT);

  txArbState_t                  state;
  txArbState_t                  stateNext;
  logic [C_PTR_W-1:0]           rPtr;
  logic [C_PTR_W-1:0]           winner;
  logic [C_UART_DATA_WIDTH-1:0] txDataReg;
  logic [C_CNT_W-1:0]           busyCnt;

  logic [C_N_REQ-1:0]           pickOneHot;
  logic                         pickFound;
  logic [C_PTR_W-1:0]           pickIdx;
  logic [C_UART_DATA_WIDTH-1:0] pickWord;
  logic [C_N_REQ-1:0]           winnerOneHot;
  logic                         busyTimeout;

  rr_select #(
    .C_N     (C_N_REQ),
    .C_PTR_W (C_PTR_W)
  ) uRrSelect (
    .req   (bus.reqValid),
    .rPtr  (rPtr),
    .grant (pickOneHot),
    .found (pickFound)
  );

  // Encode the picker's one-hot result and fetch the matching packed word.
  always_comb begin
    pickIdx  = '0;
    pickWord = '0;
    for (int unsigned i = 0; i < C_N_REQ; i++) begin
      if (pickOneHot[i]) begin
        pickIdx  = C_PTR_W'(i);
        pickWord = bus.reqData[i*C_UART_DATA_WIDTH +: C_UART_DATA_WIDTH];
      end
    end
  end

  assign busyTimeout = (busyCnt == C_CNT_W'(C_BUSY_TIMEOUT - 1));

  // State register plus the datapath registers it owns.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state     <= sIDLE;
      rPtr      <= '0;
      winner    <= '0;
      txDataReg <= '0;
      busyCnt   <= '0;
    end else begin
      state <= stateNext;
      unique case (state)
        sIDLE: begin
          if (enable && pickFound) begin
            winner    <= pickIdx;
            txDataReg <= pickWord;
          end
        end
        sSEND: busyCnt <= '0;
        sWAITB: begin
          if (busyCnt != '1) busyCnt <= busyCnt + 1'b1;
        end
        sDONE, sERR: begin
          rPtr <= (winner == C_PTR_W'(C_N_REQ - 1)) ? '0 : winner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode; txErr takes priority over busy edges and timeout.
  always_comb begin
    stateNext = state;
    unique case (state)
      sIDLE:  if (enable && pickFound) stateNext = sSEND;
      sSEND:  stateNext = sWAITB;
      sWAITB: begin
        if (bus.txErr)       stateNext = sERR;
        else if (bus.txBusy) stateNext = sWAITD;
        else if (busyTimeout) stateNext = sERR;
      end
      sWAITD: begin
        if (bus.txErr)        stateNext = sERR;
        else if (!bus.txBusy) stateNext = sDONE;
      end
      sDONE, sERR: stateNext = sIDLE;
      default:     stateNext = sIDLE;
    endcase
  end

  // One-hot view of the registered winner index.
  always_comb begin
    winnerOneHot = '0;
    for (int unsigned i = 0; i < C_N_REQ; i++) begin
      winnerOneHot[i] = (winner == C_PTR_W'(i));
    end
  end

  assign bus.txSend   = (state == sSEND);
  assign bus.txData   = txDataReg;
  assign bus.reqGrant = (state inside {sSEND, sWAITB, sWAITD, sDONE, sERR}) ? winnerOneHot : '0;
  assign bus.reqDone  = (state == sDONE) ? winnerOneHot : '0;
  assign bus.reqErr   = (state == sERR)  ? winnerOneHot : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a scoreboard of expected transmissions.
module tb_uart_tx_arbiter;

  localparam int W = 8;
  localparam int N = 3;

  typedef struct {
    int         idx;
    logic [7:0] data;
    bit         isErr;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rstb;
  logic enable;

  uart_tx_arbiter_if #(.C_UART_DATA_WIDTH(W), .C_N_REQ(N)) bus();

  uart_tx_arbiter #(
    .C_UART_DATA_WIDTH (W),
    .C_N_REQ           (N),
    .C_BUSY_TIMEOUT    (16)
  ) dut (
    .clk    (clk),
    .rstb   (rstb),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   reqLeft[N];
  int   cyc = 0;
  int   sendCyc = 0;
  int   lastEnd = -1;
  int   nSend = 0;
  bit   prevPulse = 0;

  // Tx model: 0 = normal 10-clock busy, 1 = never busy, 2 = txErr mid-word for errIdx.
  int txMode = 0;
  int errIdx = 0;
  int busyLeft = 0;

  always @(negedge clk) begin
    bus.txErr = 1'b0;
    if (busyLeft > 0) begin
      busyLeft--;
      if (txMode == 2 && busyLeft == 5 && bus.reqGrant[errIdx] === 1'b1) begin
        bus.txErr = 1'b1;
        busyLeft  = 0;
      end
    end
    if (bus.txSend === 1'b1 && txMode != 1) busyLeft = 10;
    bus.txBusy = (busyLeft > 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] data, input bit isErr, input int lat);
    exp_t e;
    e.idx = idx; e.data = data; e.isErr = isErr; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic setReq(input int idx, input logic [7:0] data, input int count);
    bus.reqData[idx*W +: W] = data;
    reqLeft[idx]            = count;
    bus.reqValid[idx]       = 1'b1;
  endtask

  // One clock: observe outputs mid-cycle, compare against the scoreboard, model requesters.
  task automatic tick();
    exp_t e;
    bit   pulse;
    @(negedge clk);
    cyc++;
    if (bus.txSend === 1'b1) begin
      nSend++;
      if (sb.size() == 0) check("unexpected_send", 32'd1, 32'd0);
      else begin
        check("grant_at_send", 32'(bus.reqGrant), 32'd1 << sb[0].idx);
        check("txData", 32'(bus.txData), 32'(sb[0].data));
        if (lastEnd >= 0) check("idle_gap", 32'(cyc - lastEnd >= 2), 32'd1);
      end
      sendCyc = cyc;
    end
    pulse = (|bus.reqDone) || (|bus.reqErr);
    if (pulse) begin
      if (sb.size() == 0) check("unexpected_pulse", 32'({bus.reqDone, bus.reqErr}), 32'd0);
      else begin
        e = sb.pop_front();
        check("done_vec", 32'(bus.reqDone), e.isErr ? 32'd0 : (32'd1 << e.idx));
        check("err_vec", 32'(bus.reqErr), e.isErr ? (32'd1 << e.idx) : 32'd0);
        if (e.lat > 0) check("latency", 32'(cyc - sendCyc), 32'(e.lat));
        for (int i = 0; i < N; i++) begin
          if ((bus.reqDone[i] || bus.reqErr[i]) && reqLeft[i] > 0) begin
            reqLeft[i]--;
            if (reqLeft[i] == 0) bus.reqValid[i] = 1'b0;
          end
        end
      end
      lastEnd = cyc;
    end else if (prevPulse) begin
      check("grant_clear", 32'(bus.reqGrant), 32'd0);
    end
    prevPulse = pulse;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    tick();
    tick();
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_grant"}, 32'(bus.reqGrant), 32'd0);
    check({tag, "_done"},  32'(bus.reqDone),  32'd0);
    check({tag, "_err"},   32'(bus.reqErr),   32'd0);
    check({tag, "_send"},  32'(bus.txSend),   32'd0);
    check({tag, "_data"},  32'(bus.txData),   32'd0);
  endtask

  initial begin
    int sendsBefore;
    rstb         = 1'b0;
    enable       = 1'b0;
    bus.reqValid = '0;
    bus.reqData  = '0;
    for (int i = 0; i < N; i++) reqLeft[i] = 0;
    tick(); tick(); tick();
    checkAllZero("reset");
    rstb = 1'b1;
    tick();

    // Single request on requester 1.
    enable = 1'b1;
    push(1, 8'hA5, 1'b0, 11);
    setReq(1, 8'hA5, 1);
    tick();
    check("send_one_cycle_after_grant", 32'(bus.txSend), 32'd1);
    tick();
    check("send_single_cycle", 32'(bus.txSend), 32'd0);
    drain(100);

    // All three at once from reset, two passes.
    rstb = 1'b0; tick(); tick(); rstb = 1'b1;
    push(0, 8'h10, 1'b0, 11); push(1, 8'h20, 1'b0, 11); push(2, 8'h30, 1'b0, 11);
    setReq(0, 8'h10, 1); setReq(1, 8'h20, 1); setReq(2, 8'h30, 1);
    drain(200);
    push(0, 8'h10, 1'b0, 11); push(1, 8'h20, 1'b0, 11); push(2, 8'h30, 1'b0, 11);
    setReq(0, 8'h10, 1); setReq(1, 8'h20, 1); setReq(2, 8'h30, 1);
    drain(200);

    // Fairness: requester 0 keeps asking, requester 2 asks once.
    push(0, 8'h40, 1'b0, 11); push(2, 8'h60, 1'b0, 11);
    push(0, 8'h40, 1'b0, 11); push(0, 8'h40, 1'b0, 11);
    setReq(0, 8'h40, 3); setReq(2, 8'h60, 1);
    drain(300);

    // Busy never rises: timeout error on requester 1.
    txMode = 1;
    push(1, 8'h77, 1'b1, 17);
    setReq(1, 8'h77, 1);
    drain(100);
    txMode = 0;

    // txErr during the busy phase of requester 2, then requester 0 completes.
    txMode = 2;
    errIdx = 2;
    push(2, 8'h5A, 1'b1, 6); push(0, 8'hC3, 1'b0, 11);
    setReq(2, 8'h5A, 1); setReq(0, 8'hC3, 1);
    drain(200);
    txMode = 0;

    // Reset while waiting for busy to fall.
    push(1, 8'h99, 1'b0, 11);
    setReq(1, 8'h99, 1);
    tick();
    check("pre_reset_send", 32'(bus.txSend), 32'd1);
    tick(); tick(); tick();
    check("pre_reset_grant", 32'(bus.reqGrant), 32'd2);
    rstb         = 1'b0;
    bus.reqValid = '0;
    for (int i = 0; i < N; i++) reqLeft[i] = 0;
    sb.delete();
    tick();
    checkAllZero("mid_reset");
    rstb = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // enable low holds off grants; a word in flight finishes after enable drops.
    enable = 1'b0;
    sendsBefore = nSend;
    setReq(0, 8'h11, 1); setReq(1, 8'h22, 1);
    for (int i = 0; i < 8; i++) tick();
    check("no_send_disabled", 32'(nSend), 32'(sendsBefore));
    push(0, 8'h11, 1'b0, 11);
    enable = 1'b1;
    tick();
    check("send_after_enable", 32'(bus.txSend), 32'd1);
    check("grant_after_enable", 32'(bus.reqGrant), 32'd1);
    enable = 1'b0;
    drain(100);
    for (int i = 0; i < 10; i++) tick();
    check("held_after_disable", 32'(nSend), 32'(sendsBefore + 1));
    push(1, 8'h22, 1'b0, 11);
    enable = 1'b1;
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
